// File: rtl/mult_pkg.sv
// Shared types and sizes for the 4x4 approximate multiplier datapath.
package mult_pkg;

  localparam int WIDTH = 4;
  localparam int PP_W  = WIDTH * WIDTH;

  // Operating modes of the operand staging stage.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ppgen_state_e;

  // One beat as carried between pipeline stages.
  typedef struct packed {
    logic [PP_W-1:0]  pp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             last;
  } pp_beat_t;

endpackage

// File: rtl/pp_skid.sv
// Two-entry skid buffer (main + skid register) over pp_beat_t.
//
// Handshake: a beat moves across an interface on a rising edge where its
// valid and ready are both high. push_ready depends only on registered state
// (skid entry empty), so there is no combinational path from pop_ready back
// to push_ready. pop_valid never drops and pop_data never changes while
// pop_valid=1 and pop_ready=0.
module pp_skid
  import mult_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_valid,
  input  pp_beat_t push_data,
  output logic     push_ready,
  output logic     pop_valid,
  output pp_beat_t pop_data,
  input  logic     pop_ready
);

  pp_beat_t main_q;
  pp_beat_t skid_q;
  logic     main_v;
  logic     skid_v;

  assign push_ready = !skid_v;
  assign pop_valid  = main_v;
  assign pop_data   = main_q;

  // Main holds the presented beat; skid catches one extra beat during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      // Full: no push possible; a pop moves the skid beat into main.
      if (pop_ready) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (push_valid) begin
      if (!main_v || pop_ready) begin
        // Empty main, or main leaving this edge: replace in place, no bubble.
        main_q <= push_data;
        main_v <= 1'b1;
      end else begin
        skid_q <= push_data;
        skid_v <= 1'b1;
      end
    end else if (pop_ready) begin
      main_v <= 1'b0;
    end
  end

endmodule

// File: rtl/ppgen.sv
// Operand staging and AND-array partial-product generation. Operands come
// from the external handshake (IDLE) or from an internal exhaustive counter
// (SWEEP); the resulting beats leave through a two-entry skid buffer.
//
// Handshake: in_* transfers on a rising edge with in_valid & in_ready;
// out_* transfers on a rising edge with out_valid & out_ready. in_ready is
// built from registered state only.
module ppgen #(
  parameter int WIDTH = 4,
  parameter int PP_W  = WIDTH * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP_W-1:0]  out_pp,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_last,
  output logic [1:0]       dbg_state
);

  import mult_pkg::*;

  ppgen_state_e     state_q;
  logic [7:0]       cnt_q;

  logic             src_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             src_last;
  logic [PP_W-1:0]  pp_w;
  pp_beat_t         src_beat;

  logic             push_ready;
  logic             pop_valid;
  pp_beat_t         pop_data;
  logic             accept;
  logic             buf_empty_next;

  // Select the operand source for the current mode.
  always_comb begin
    src_valid = 1'b0;
    src_a     = in_a;
    src_b     = in_b;
    src_last  = 1'b0;
    case (state_q)
      IDLE: begin
        src_valid = in_valid;
      end
      SWEEP: begin
        src_valid = 1'b1;
        src_a     = cnt_q[3:0];
        src_b     = cnt_q[7:4];
        src_last  = (cnt_q == 8'd255);
      end
      default: begin
        src_valid = 1'b0;
      end
    endcase
  end

  // AND array: bit WIDTH*i+j has weight i+j.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      assign pp_w[WIDTH*i+j] = src_a[j] & src_b[i];
    end
  end

  assign src_beat = '{pp: pp_w, a: src_a, b: src_b, last: src_last};
  assign accept   = src_valid & push_ready;

  // True when nothing will remain buffered after this edge.
  assign buf_empty_next = push_ready & (!pop_valid | out_ready);

  pp_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (src_valid),
    .push_data  (src_beat),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (out_ready)
  );

  // Mode sequencing and the sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sweep_start) begin
            state_q <= SWEEP;
            cnt_q   <= 8'd0;
          end
        end
        SWEEP: begin
          if (accept) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'd255) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (buf_empty_next) begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = !rst & (state_q == IDLE) & push_ready;
  assign sweep_busy = (state_q == SWEEP) | (state_q == DRAIN);
  assign sweep_done = (state_q == DONE);
  assign dbg_state  = state_q;

  assign out_valid = pop_valid;
  assign out_pp    = pop_data.pp;
  assign out_a     = pop_data.a;
  assign out_b     = pop_data.b;
  assign out_last  = pop_data.last;

endmodule

// File: tb/tb_ppgen.sv
// Self-checking bench for ppgen: random traffic against a queue-based model.
module tb_ppgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_a = 4'd0;
  logic [3:0]  in_b = 4'd0;
  logic        sweep_start = 1'b0;
  logic        sweep_busy;
  logic        sweep_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pp;
  logic [3:0]  out_a;
  logic [3:0]  out_b;
  logic        out_last;
  logic [1:0]  dbg_state;

  ppgen dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pp      (out_pp),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_last    (out_last),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected beats packed as {last, a, b}.
  logic [8:0] exp_q[$];

  function automatic logic [15:0] model_pp(input logic [3:0] a, input logic [3:0] b);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) r = r | (16'(a) << (4 * i));
    return r;
  endfunction

  function automatic int weighted_sum(input logic [15:0] pp);
    int s;
    s = 0;
    for (int k = 0; k < 16; k++)
      if (pp[k]) s += 1 << ((k / 4) + (k % 4));
    return s;
  endfunction

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;  // 0: hold low, 1: hold high, 2: random
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  bit          mon_en = 0;
  bit          sweep_on = 0;
  bit          done_exp = 0;
  bit          prev_stall = 0;
  logic [24:0] prev_d = '0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          done_cnt = 0;
  int          last_pop_cyc = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (mon_en && !rst) begin
      check("done_pulse", sweep_done, done_exp);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_pp, out_a, out_b, out_last}, prev_d);
      end
      if (sweep_on) check("in_ready_sweep", in_ready, 0);
      done_exp = 0;
      if (out_valid && out_ready) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_a", out_a, e[7:4]);
          check("beat_b", out_b, e[3:0]);
          check("beat_last", out_last, e[8]);
          check("beat_pp", out_pp, model_pp(e[7:4], e[3:0]));
          check("beat_wsum", weighted_sum(out_pp), e[7:4] * e[3:0]);
          done_exp = e[8];
        end
      end
      if (sweep_done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_d     = {out_pp, out_a, out_b, out_last};
      if (in_valid && in_ready) exp_q.push_back({1'b0, in_a, in_b});
    end else begin
      prev_stall = 0;
      done_exp   = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(posedge clk); #2;
    rst = 1'b1;
    in_valid = 1'b0;
    sweep_on = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_outs_1", {in_ready, out_valid, out_pp, out_a, out_b, out_last,
                         sweep_busy, sweep_done, dbg_state}, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_outs_2", {in_ready, out_valid, out_pp, out_a, out_b, out_last,
                         sweep_busy, sweep_done, dbg_state}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int t;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 200) check("send_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 600; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic start_sweep(output int start_cyc);
    @(posedge clk); #2;
    sweep_start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kk;
      kk = 8'(k);
      exp_q.push_back({(k == 255), kk[3:0], kk[7:4]});
    end
    @(posedge clk); #2;
    sweep_start = 1'b0;
    sweep_on = 1;
    start_cyc = cyc;
    check("sweep_busy_on", sweep_busy, 1);
  endtask

  task automatic wait_done();
    int t;
    int base;
    base = done_cnt;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done_cnt != base) break;
    end
    check("sweep_done_seen", (done_cnt != base), 1);
    sweep_on = 0;
    check("sweep_all_beats", exp_q.size(), 0);
    @(posedge clk); #2;
    check("sweep_busy_off", sweep_busy, 0);
  endtask

  task automatic wait_pops(input int base, input int n);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (pop_cnt - base >= n) break;
    end
    check("wait_pops", (pop_cnt - base >= n), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sc;
    int p0;

    reset_dut();
    mon_en = 1;

    // Single operation with fixed expected values.
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #2;
    send(4'd5, 4'd3);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_pp", out_pp, 16'h0055);
    check("single_a", out_a, 5);
    check("single_b", out_b, 3);
    check("single_last", out_last, 0);
    check("single_wsum", weighted_sum(out_pp), 15);
    drain();

    // Random external traffic with random backpressure.
    ready_mode = 2;
    repeat (40) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    ready_mode = 1;
    drain();

    // Backpressure: two beats buffered, then in_ready falls.
    ready_mode = 0;
    @(posedge clk); #2;
    send(4'd1, 4'd1);
    send(4'd2, 4'd1);
    in_a = 4'd3;
    in_b = 4'd1;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_buffered", exp_q.size(), 2);
    check("bp_out_a", out_a, 1);
    ready_mode = 1;
    send(4'd3, 4'd1);
    send(4'd4, 4'd1);
    drain();

    // Full sweep without backpressure: 256 consecutive beats.
    p0 = pop_cnt;
    start_sweep(sc);
    wait_done();
    check("sweep_count", pop_cnt - p0, 256);
    check("sweep_consecutive", last_pop_cyc - sc, 257);

    // Sweep under random backpressure with an ignored second start.
    ready_mode = 2;
    p0 = pop_cnt;
    start_sweep(sc);
    wait_pops(p0, 50);
    @(posedge clk); #2;
    sweep_start = 1'b1;
    @(posedge clk); #2;
    sweep_start = 1'b0;
    wait_done();
    check("rsweep_count", pop_cnt - p0, 256);
    ready_mode = 1;

    // Reset in the middle of a sweep aborts it.
    p0 = pop_cnt;
    start_sweep(sc);
    wait_pops(p0, 99);
    reset_dut();
    p0 = pop_cnt;
    repeat (10) begin
      @(negedge clk);
      check("abort_no_beat", out_valid, 0);
    end
    check("abort_no_pops", pop_cnt - p0, 0);

    // A new sweep after the abort starts again from zero.
    p0 = pop_cnt;
    start_sweep(sc);
    wait_done();
    check("restart_count", pop_cnt - p0, 256);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppgen.md
# ppgen

Operand staging and partial-product generation stage for the 4x4 unsigned approximate multiplier datapath. It accepts operand pairs over a valid/ready handshake, or generates them itself in an exhaustive sweep, and forms the 16 AND-array partial products. It forwards them, registered and buffered, to the downstream `ppcom` compression tree. The forwarded operands let the downstream error checker compute the exact product alongside the approximate one.

## Interface
Parameters:
- `WIDTH`, default 4: operand width. Only 4 is supported.
- `PP_W`, default `WIDTH*WIDTH` (16): partial-product vector width. Derived; never override.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  external operand pair valid.
- `in_ready`  out  1  stage can accept an external pair.
- `in_a`  in  4  multiplicand.
- `in_b`  in  4  multiplier.
- `sweep_start`  in  1  single-cycle request to start the exhaustive 256-pair sweep.
- `sweep_busy`  out  1  high while in SWEEP or DRAIN.
- `sweep_done`  out  1  one-cycle pulse when the sweep has fully drained.
- `out_valid`  out  1  `out_*` holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_pp`  out  16  partial products. `out_pp[4*i+j] = a[j] & b[i]`, weight i+j.
- `out_a`, `out_b`  out  4 each  operands that produced `out_pp`.
- `out_last`  out  1  marks the final sweep beat (a=15, b=15).

## Operation
- FSM states:
  - IDLE: external operands flow through.
  - SWEEP: internal counter drives operands.
  - DRAIN: wait for the output buffer to empty.
  - DONE: one cycle; `sweep_done`=1; next state IDLE.
- Transitions:
  - IDLE -> SWEEP when `sweep_start`=1. An external transfer handshaked in that same cycle is still accepted, so ordering is preserved.
  - SWEEP -> DRAIN when counter value 255 is accepted into the buffer.
  - DRAIN -> DONE when both buffer entries are empty.
  - `sweep_start` outside IDLE is ignored.
- Sweep counter `cnt[7:0]`:
  - Drives a=`cnt[3:0]`, b=`cnt[7:4]`.
  - Resets to 0 on entering SWEEP.
  - Increments only on an accepted beat; no wrap is used.
  - The beat with cnt=255 sets `out_last`=1. All other beats, including every external beat, carry `out_last`=0.
- In SWEEP, DRAIN and DONE: `in_ready`=0 and `in_a`/`in_b` are ignored.
- Output buffer: two-entry skid (main plus skid register). Each entry stores pp, a, b and last.
  - Accept condition: source valid and the skid entry empty.
  - `in_ready` = (state==IDLE) & !skid_valid. It is a registered term, with no combinational path from `out_ready`.
- Reset: state IDLE, `cnt`=0, both entries invalid.
  - All outputs 0: `in_ready`=0 during reset, then 1 in the first cycle after reset.
  - `rst` mid-sweep aborts immediately. Buffered beats are discarded; `sweep_done` does not pulse.

## Timing
- Latency: a beat accepted at edge N is presented with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: 1 beat per cycle while `out_ready`=1. A full sweep with no backpressure gives 256 beats on 256 consecutive cycles.
- Handshake: `out_*` is held stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a transfer.
- Backpressure sequence:
  - First stalled beat stays in main.
  - The next accepted beat goes to skid, and `in_ready` falls on the following cycle.
  - When `out_ready` returns, main drains, skid moves to main, and `in_ready` returns after one cycle.
- Simultaneous push and pop with the skid empty: main is replaced in place with no bubble.
- `sweep_done` pulses in the cycle after the last beat (`out_last`) has been taken by the downstream.

## Structure
- Shared package `mult_pkg` holds:
  - `WIDTH`, `PP_W` localparams.
  - The `ppgen_state_e` enum (IDLE, SWEEP, DRAIN, DONE).
  - A `pp_beat_t` struct {pp, a, b, last}.
- Sub-module `pp_skid` is the two-entry skid buffer over `pp_beat_t`. It is reusable at the `ppcom` output register.
- The AND-array is a combinational generate loop inside `ppgen`, located before the buffer.

## Test plan
- Reset: hold `rst` 3 cycles, including mid-traffic -> all outputs 0 during reset; `in_ready`=1 on the first cycle after reset.
- Single op: a=5, b=3, `out_ready`=1 -> one cycle later `out_pp`=16'h0055, `out_a`=5, `out_b`=3, `out_last`=0. The weighted sum of `out_pp` equals 15.
- Backpressure: stream a=1..4, b=1; `out_ready`=0 for 4 cycles -> beats 1 and 2 buffered; `in_ready` low after 2 accepts; then beats 1,2,3,4 emerge in order with no loss or duplication.
- Sweep: pulse `sweep_start` with `out_ready`=1 ->
  - 256 consecutive beats, a=cnt[3:0] and b=cnt[7:4].
  - Last beat has a=15, b=15, `out_pp`=16'hFFFF, `out_last`=1.
  - `sweep_done` pulses once; `sweep_busy` falls.
- Sweep with random `out_ready` (50%) -> every pair 0..255 seen exactly once and in order; `in_ready`=0 throughout; a second `sweep_start` mid-sweep is ignored.
- `rst` at cnt=100 -> no further beats; no `sweep_done` pulse; a new sweep restarts at cnt=0.
